// File: rtl/demux_4_32bits.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and invalid-select drop/flag.
// Optional saturating drop counter enabled by defining DEMUX_ERRCNT_EN.
module demux_4_32bits #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       DEMUXop,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic             sel_err,
    output logic [7:0]       err_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [3:0]       r_out_valid;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic [WIDTH-1:0] r_data3;
    logic             r_sel_err;

    logic w_in_ready;
    logic w_accept;
    logic w_op_ok;
    logic w_load;
    logic w_release;

    function automatic logic [3:0] f_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Ready is combinational so a draining lane can refill in the same cycle.
    assign w_in_ready = (r_state == ST_IDLE) || out_ready[r_sel];
    assign w_accept   = in_valid && w_in_ready;
    assign w_op_ok    = (DEMUXop[2] == 1'b0);
    assign w_load     = w_accept && w_op_ok;
    assign w_release  = w_in_ready && !w_load;

    // Lane FSM: load on a valid accept, release when idle/drained, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 2'd0;
            r_out_valid <= 4'b0000;
            r_data0     <= {WIDTH{1'b0}};
            r_data1     <= {WIDTH{1'b0}};
            r_data2     <= {WIDTH{1'b0}};
            r_data3     <= {WIDTH{1'b0}};
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= w_accept && !w_op_ok;
            if (w_load) begin
                r_state     <= ST_HOLD;
                r_sel       <= DEMUXop[1:0];
                r_out_valid <= f_onehot(DEMUXop[1:0]);
                case (DEMUXop[1:0])
                    2'd0:    r_data0 <= in_data;
                    2'd1:    r_data1 <= in_data;
                    2'd2:    r_data2 <= in_data;
                    default: r_data3 <= in_data;
                endcase
            end else if (w_release) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 4'b0000;
            end else begin
                r_state     <= r_state;
                r_out_valid <= r_out_valid;
            end
        end
    end

`ifdef DEMUX_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating count of dropped invalid-select words, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= 8'd0;
        end else if (w_accept && !w_op_ok && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out0_data = r_data0;
    assign out1_data = r_data1;
    assign out2_data = r_data2;
    assign out3_data = r_data3;
    assign sel_err   = r_sel_err;

endmodule
